texture_loader: RTL and testbench
=================================

// Module: texture_loader
// PURPOSE
//  Write-side counterpart of the texture read path: accepts a byte stream (host/UART/JTAG
//  bridge) carrying one full texture image and writes 12-bit RGB444 texels into one of
//  N_TEX texture RAM slots. Sits between the host byte source and the texture RAM write
//  port; the VGA-side texture readers consume the same RAMs on vga_clk.
// PARAMETERS
//  TEX_W   32                       texels per texture row
//  TEX_H   32                       texture rows
//  N_TEX   4                        texture slots (slot index 2 bits)
//  ADDR_W  $clog2(TEX_W*TEX_H)      texel address width (10 at defaults)
// PORTS
//  vga_clk     in   1       single clock; all logic rising-edge
//  reset       in   1       synchronous, active-high
//  in_data     in   8       stream byte
//  in_valid    in   1       in_data valid; byte accepted when in_valid & in_ready
//  in_ready    out  1       loader can accept a byte this cycle
//  abort       in   1       drop current image, return to IDLE
//  wr_en       out  1       texel write strobe to texture RAM (one cycle per texel)
//  wr_tex      out  2       destination slot
//  wr_addr     out  ADDR_W  texel address, row-major: y*TEX_W + x
//  wr_data     out  12      {red[3:0], green[3:0], blue[3:0]}
//  busy        out  1       image load in progress (state != IDLE)
//  done        out  1       one-cycle pulse: last texel written
//  hdr_err     out  1       one-cycle pulse: bad header byte rejected
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0 during reset cycle, 1 from next cycle; wr_en, done,
//   hdr_err, busy=0; wr_tex, wr_addr, wr_data=0; internal texel counter=0.
//  Stream format per image: header byte, then TEX_W*TEX_H texel pairs:
//   header = {6'b101000, slot[1:0]} (0xA0..0xA3); byte A = {red, green}; byte B = {4'hx, blue}
//   (upper nibble of byte B ignored).
//  FSM (advances only on accepted byte unless stated):
//   IDLE: header valid -> latch slot into wr_tex, counter=0, -> HI. Any other byte ->
//    hdr_err pulse next cycle, stay IDLE (byte consumed).
//   HI:   latch red/green -> LO.
//   LO:   latch blue; next cycle wr_en=1, wr_addr=counter, wr_data={r,g,b}; counter+1.
//    If counter was TEX_W*TEX_H-1 -> DONE, else -> HI.
//   DONE: lasts exactly one cycle; done=1 (same cycle as final wr_en); in_ready=0; -> IDLE.
//  in_ready=1 in IDLE/HI/LO, 0 in DONE and during reset. No backpressure on write port:
//   RAM accepts a write every cycle.
//  Latency: accepted byte B at cycle t -> wr_en at t+1. Max throughput: 1 texel / 2 cycles.
//  wr_en, done, hdr_err are registered single-cycle pulses; wr_addr/wr_data/wr_tex hold
//   last values when wr_en=0.
//  Counter is ADDR_W bits; never wraps inside an image (terminates at TEX_W*TEX_H-1);
//   reset to 0 on every new header.
//  in_valid low: FSM holds state; gaps between bytes of any length allowed.
//  abort: highest priority after reset; next cycle state=IDLE, counter=0, no wr_en/done
//   for the byte presented with abort (byte not consumed, in_ready still reported),
//   already-written texels are not undone. abort in IDLE is a no-op.
//  reset mid-image: same as abort plus all outputs to reset values; no partial write.
//  busy=1 in HI, LO, DONE.
// TESTING (bench uses TEX_W=4, TEX_H=2 -> 8 texels unless noted)
//  1 Header 0xA2 then 8 pairs (0x12,0x03),(0x45,0x06)... -> 8 wr_en, wr_tex=2, addr 0..7,
//    first wr_data=12'h123, second 12'h456; done with addr 7; busy falls after done.
//  2 Header 0x5A in IDLE -> hdr_err one cycle, no wr_en, busy=0; then 0xA1 accepted normally.
//  3 Random in_valid gaps (0-5 cycles) during image -> identical writes as scenario 1,
//    each wr_en exactly 1 cycle after byte B; in_ready=0 only in DONE cycle.
//  4 abort asserted after 3 texels -> IDLE next cycle, no further wr_en, no done; new
//    header 0xA0 restarts at addr 0.
//  5 reset asserted between byte A and B of texel 5 -> no wr_en, all outputs 0, in_ready
//    returns 1 after reset deasserts; full image then loads cleanly.
//  6 Byte B = 0xF7 -> wr_data blue nibble = 7 (upper nibble ignored); defaults (32x32):
//    1024 writes, last wr_addr=10'd1023, done coincident.

Source files
------------

// File: rtl/texture_loader.sv
// Byte-stream texture loader: parses a header plus RGB444 texel pairs and drives
// one-cycle texel writes into the selected texture RAM slot.
module texture_loader #(
   parameter int TEX_W  = 32,
   parameter int TEX_H  = 32,
   parameter int N_TEX  = 4,
   parameter int ADDR_W = $clog2(TEX_W * TEX_H)
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              abort,
   output logic              wr_en,
   output logic [1:0]        wr_tex,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [11:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              hdr_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEX_W * TEX_H - 1);
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
   localparam logic [2:0]        N_TEX_L   = 3'(N_TEX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
   logic [7:0]        rg_r, rg_nxt_s;
   logic              in_ready_r, wr_en_r, busy_r, done_r, hdr_err_r;
   logic [1:0]        wr_tex_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [11:0]       wr_data_r;
   logic              in_ready_nxt_s, wr_en_nxt_s, busy_nxt_s, done_nxt_s, hdr_err_nxt_s;
   logic [1:0]        wr_tex_nxt_s;
   logic [ADDR_W-1:0] wr_addr_nxt_s;
   logic [11:0]       wr_data_nxt_s;
   logic              accept_s, hdr_ok_s, last_s;

   assign accept_s = in_valid & in_ready_r;
   assign hdr_ok_s = (in_data[7:2] == 6'b101000) && ({1'b0, in_data[1:0]} < N_TEX_L);
   assign last_s   = (cnt_r == LAST_ADDR);

   // State register
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort overrides any byte acceptance
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = (accept_s && hdr_ok_s) ? ST_HI : ST_IDLE;
            ST_HI:   state_nxt_s = accept_s ? ST_LO : ST_HI;
            ST_LO: begin
               if (accept_s) begin
                  state_nxt_s = last_s ? ST_DONE : ST_HI;
               end else begin
                  state_nxt_s = ST_LO;
               end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Output and datapath next values; everything lands in registers below
   always_comb begin
      wr_en_nxt_s   = 1'b0;
      done_nxt_s    = 1'b0;
      hdr_err_nxt_s = 1'b0;
      wr_tex_nxt_s  = wr_tex_r;
      wr_addr_nxt_s = wr_addr_r;
      wr_data_nxt_s = wr_data_r;
      cnt_nxt_s     = cnt_r;
      rg_nxt_s      = rg_r;
      if (abort) begin
         cnt_nxt_s = {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && hdr_ok_s) begin
                  wr_tex_nxt_s = in_data[1:0];
                  cnt_nxt_s    = {ADDR_W{1'b0}};
               end else if (accept_s) begin
                  hdr_err_nxt_s = 1'b1;
               end else begin
                  hdr_err_nxt_s = 1'b0;
               end
            end
            ST_HI: begin
               if (accept_s) begin
                  rg_nxt_s = in_data;
               end else begin
                  rg_nxt_s = rg_r;
               end
            end
            ST_LO: begin
               if (accept_s) begin
                  wr_en_nxt_s   = 1'b1;
                  wr_addr_nxt_s = cnt_r;
                  wr_data_nxt_s = {rg_r, in_data[3:0]};
                  done_nxt_s    = last_s;
                  cnt_nxt_s     = last_s ? {ADDR_W{1'b0}} : cnt_r + ONE_ADDR;
               end else begin
                  wr_en_nxt_s = 1'b0;
               end
            end
            ST_DONE: wr_en_nxt_s = 1'b0;
            default: wr_en_nxt_s = 1'b0;
         endcase
      end
      in_ready_nxt_s = (state_nxt_s != ST_DONE);
      busy_nxt_s     = (state_nxt_s != ST_IDLE);
   end

   // Output and datapath registers
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         in_ready_r <= 1'b0;
         wr_en_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         hdr_err_r  <= 1'b0;
         wr_tex_r   <= 2'd0;
         wr_addr_r  <= {ADDR_W{1'b0}};
         wr_data_r  <= 12'd0;
         cnt_r      <= {ADDR_W{1'b0}};
         rg_r       <= 8'd0;
      end else begin
         in_ready_r <= in_ready_nxt_s;
         wr_en_r    <= wr_en_nxt_s;
         busy_r     <= busy_nxt_s;
         done_r     <= done_nxt_s;
         hdr_err_r  <= hdr_err_nxt_s;
         wr_tex_r   <= wr_tex_nxt_s;
         wr_addr_r  <= wr_addr_nxt_s;
         wr_data_r  <= wr_data_nxt_s;
         cnt_r      <= cnt_nxt_s;
         rg_r       <= rg_nxt_s;
      end
   end

   assign in_ready = in_ready_r;
   assign wr_en    = wr_en_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign hdr_err  = hdr_err_r;
   assign wr_tex   = wr_tex_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_texture_loader.sv
// Randomized bench for texture_loader: a 4x2 instance for protocol corners and a
// default 32x32 instance for the full-size image; expected writes come from the image.
module tb_texture_loader;

   logic       clk = 1'b0;
   logic       reset, abort, sel, in_valid;
   logic [7:0] in_data;
   always #5 clk = ~clk;

   logic       rdy_a, en_a, busy_a, done_a, err_a;
   logic [1:0] tex_a;
   logic [2:0] addr_a;
   logic [11:0] data_a;
   logic       rdy_b, en_b, busy_b, done_b, err_b;
   logic [1:0] tex_b;
   logic [9:0] addr_b;
   logic [11:0] data_b;
   logic       val_a, val_b;
   assign val_a = in_valid & ~sel;
   assign val_b = in_valid & sel;

   texture_loader #(.TEX_W(4), .TEX_H(2)) dut_a (
      .vga_clk(clk), .reset(reset), .in_data(in_data), .in_valid(val_a), .in_ready(rdy_a),
      .abort(abort), .wr_en(en_a), .wr_tex(tex_a), .wr_addr(addr_a), .wr_data(data_a),
      .busy(busy_a), .done(done_a), .hdr_err(err_a));

   texture_loader dut_b (
      .vga_clk(clk), .reset(reset), .in_data(in_data), .in_valid(val_b), .in_ready(rdy_b),
      .abort(1'b0), .wr_en(en_b), .wr_tex(tex_b), .wr_addr(addr_b), .wr_data(data_b),
      .busy(busy_b), .done(done_b), .hdr_err(err_b));

   logic        m_ready, m_en, m_busy, m_done, m_err;
   logic [1:0]  m_tex;
   logic [9:0]  m_addr;
   logic [11:0] m_data;
   assign m_ready = sel ? rdy_b  : rdy_a;
   assign m_en    = sel ? en_b   : en_a;
   assign m_busy  = sel ? busy_b : busy_a;
   assign m_done  = sel ? done_b : done_a;
   assign m_err   = sel ? err_b  : err_a;
   assign m_tex   = sel ? tex_b  : tex_a;
   assign m_addr  = sel ? addr_b : {7'd0, addr_a};
   assign m_data  = sel ? data_b : data_a;

   int checks = 0, errors = 0;
   int wr_count = 0, done_count = 0, err_count = 0;

   always @(negedge clk) begin
      if (m_en)   wr_count   <= wr_count + 1;
      if (m_done) done_count <= done_count + 1;
      if (m_err)  err_count  <= err_count + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a byte and return #1 after the edge that accepted it
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (m_ready !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      if (n >= 20) check_eq("rdy_timeout", {31'd0, m_ready}, 32'd1);
      tick(1);
      in_valid = 1'b0;
   endtask

   task automatic send_texel(input logic [1:0] slot, input int addr, input int last,
                             input logic [11:0] px, input logic [3:0] hi, input int gap);
      send_byte(px[11:4]);
      tick(gap);
      send_byte({hi, px[3:0]});
      check_eq("wr_en",   {31'd0, m_en}, 32'd1);
      check_eq("wr_addr", {22'd0, m_addr}, addr);
      check_eq("wr_data", {20'd0, m_data}, {20'd0, px});
      check_eq("wr_tex",  {30'd0, m_tex}, {30'd0, slot});
      check_eq("done",    {31'd0, m_done}, (addr == last) ? 32'd1 : 32'd0);
      check_eq("busy",    {31'd0, m_busy}, 32'd1);
   endtask

   task automatic send_image(input logic [1:0] slot, input int n, input int max_gap, input bit rnd);
      logic [11:0] img[$];
      int w0, d0, g;
      logic [3:0] hi;
      for (int i = 0; i < n; i++)
         img.push_back(rnd ? 12'($urandom) : 12'(12'h123 + i * 12'h333));
      w0 = wr_count;
      d0 = done_count;
      send_byte({6'b101000, slot});
      check_eq("hdr_busy", {31'd0, m_busy}, 32'd1);
      check_eq("hdr_tex",  {30'd0, m_tex}, {30'd0, slot});
      for (int i = 0; i < n; i++) begin
         g  = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         hi = rnd ? 4'($urandom) : 4'h0;
         send_texel(slot, i, n - 1, img[i], hi, g);
         if (i < n - 1 && max_gap > 0) tick($urandom_range(0, max_gap));
      end
      check_eq("done_rdy",  {31'd0, m_ready}, 32'd0);
      check_eq("done_busy", {31'd0, m_busy}, 32'd1);
      tick(1);
      check_eq("post_rdy",  {31'd0, m_ready}, 32'd1);
      check_eq("post_busy", {31'd0, m_busy}, 32'd0);
      check_eq("post_done", {31'd0, m_done}, 32'd0);
      check_eq("post_wren", {31'd0, m_en}, 32'd0);
      check_eq("wr_total",  wr_count - w0, n);
      check_eq("done_total", done_count - d0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_rdy"},   {31'd0, m_ready}, 32'd0);
      check_eq({tag, "_wren"},  {31'd0, m_en}, 32'd0);
      check_eq({tag, "_busy"},  {31'd0, m_busy}, 32'd0);
      check_eq({tag, "_done"},  {31'd0, m_done}, 32'd0);
      check_eq({tag, "_err"},   {31'd0, m_err}, 32'd0);
      check_eq({tag, "_tex"},   {30'd0, m_tex}, 32'd0);
      check_eq({tag, "_addr"},  {22'd0, m_addr}, 32'd0);
      check_eq({tag, "_data"},  {20'd0, m_data}, 32'd0);
   endtask

   initial begin
      int w0, d0, e0;
      reset = 1'b1; abort = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      tick(2);
      check_reset_outputs("rst");
      reset = 1'b0;
      tick(1);
      check_eq("rst_rdy_a", {31'd0, rdy_a}, 32'd1);
      check_eq("rst_rdy_b", {31'd0, rdy_b}, 32'd1);

      // Fixed pattern image into slot 2
      send_image(2'd2, 8, 0, 1'b0);

      // Bad headers are consumed and flagged, then a good one loads normally
      e0 = err_count;
      w0 = wr_count;
      send_byte(8'h5A);
      check_eq("bad_err",  {31'd0, m_err}, 32'd1);
      check_eq("bad_busy", {31'd0, m_busy}, 32'd0);
      check_eq("bad_wren", {31'd0, m_en}, 32'd0);
      tick(1);
      check_eq("bad_err_pulse", {31'd0, m_err}, 32'd0);
      send_byte(8'hA4);
      check_eq("bad2_err", {31'd0, m_err}, 32'd1);
      tick(1);
      check_eq("bad_err_cnt", err_count - e0, 32'd2);
      check_eq("bad_no_wr", wr_count - w0, 32'd0);
      send_image(2'd1, 8, 0, 1'b1);

      // Random gaps between every byte
      for (int k = 0; k < 3; k++) send_image(2'(3 - k), 8, 5, 1'b1);

      // Abort in IDLE does nothing
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_eq("idle_abort_busy", {31'd0, m_busy}, 32'd0);
      check_eq("idle_abort_rdy",  {31'd0, m_ready}, 32'd1);
      check_eq("idle_abort_err",  {31'd0, m_err}, 32'd0);

      // Abort mid-image after three texels, with byte B presented
      w0 = wr_count;
      d0 = done_count;
      send_byte(8'hA0);
      for (int i = 0; i < 3; i++) send_texel(2'd0, i, 7, 12'($urandom), 4'h0, 0);
      send_byte(8'h9A);
      in_data = 8'h0B; in_valid = 1'b1; abort = 1'b1;
      check_eq("abort_rdy", {31'd0, m_ready}, 32'd1);
      tick(1);
      abort = 1'b0; in_valid = 1'b0;
      check_eq("abort_busy", {31'd0, m_busy}, 32'd0);
      check_eq("abort_wren", {31'd0, m_en}, 32'd0);
      tick(2);
      check_eq("abort_wr_cnt", wr_count - w0, 32'd3);
      check_eq("abort_done_cnt", done_count - d0, 32'd0);
      send_image(2'd0, 8, 0, 1'b1);

      // Reset between byte A and byte B
      w0 = wr_count;
      send_byte(8'hA3);
      for (int i = 0; i < 5; i++) send_texel(2'd3, i, 7, 12'($urandom), 4'($urandom), 0);
      send_byte(8'h77);
      in_data = 8'h0C; in_valid = 1'b1; reset = 1'b1;
      tick(1);
      check_reset_outputs("midrst");
      reset = 1'b0; in_valid = 1'b0;
      tick(1);
      check_eq("midrst_rdy_back", {31'd0, m_ready}, 32'd1);
      check_eq("midrst_wr_cnt", wr_count - w0, 32'd5);
      send_image(2'd3, 8, 0, 1'b1);

      // Default-size image: 1024 texels with random ignored upper nibbles
      sel = 1'b1;
      tick(1);
      send_image(2'd1, 1024, 0, 1'b1);
      sel = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
